led_frame_sequencer: RTL

//  Frame-level controller for bit_transmitter. Fetches NUM_LEDS colour words from the pixel

---
 rtl/led_frame_sequencer_pkg.sv | 18 +
 rtl/led_frame_sequencer_if.sv | 24 ++
 rtl/led_frame_sequencer_pixel_shifter.sv | 59 +++++
 rtl/led_frame_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/led_frame_sequencer_pkg.sv
// Shared constants for the LED frame sequencer: default geometry, FSM encodings
// and a width helper for the per-LED bit counter.
package led_frame_sequencer_pkg;

  localparam int DEF_NUM_LEDS = 64;
  localparam int DEF_COLOR_W  = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  function automatic int bidx_w(input int cw);
    return (cw > 1) ? $clog2(cw) : 1;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Pixel-memory read port plus the bit-transmitter handshake.
// master = sequencer side, slave = memory/transmitter side.
interface led_frame_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int COLOR_W = 24
);
  logic               pix_rd;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0] pix_data;
  logic               new_bit_rqst;
  logic               bit_to_transmit;
  logic               all_bits_shifted;
  logic               new_frame_rqst;

  modport master (
    output pix_rd, pix_addr, bit_to_transmit, all_bits_shifted,
    input  pix_data, new_bit_rqst, new_frame_rqst
  );

  modport slave (
    input  pix_rd, pix_addr, bit_to_transmit, all_bits_shifted,
    output pix_data, new_bit_rqst, new_frame_rqst
  );
endinterface

// File: rtl/led_frame_sequencer_pixel_shifter.sv
// Colour-word shifter: active word shifted MSB-first, a one-word prefetch buffer
// that becomes the active word after its last bit, and the bit index.
module led_frame_sequencer_pixel_shifter
  import led_frame_sequencer_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               capture,
  input  logic               shift,
  input  logic [COLOR_W-1:0] din,
  output logic               bit_out,
  output logic               last_bit
);
  localparam int BIDX_W = bidx_w(COLOR_W);
  localparam logic [BIDX_W-1:0] BIT_TOP = BIDX_W'(COLOR_W - 1);

  logic [COLOR_W-1:0] sreg_q, sreg_d;
  logic [COLOR_W-1:0] pre_buf_q, pre_buf_d;
  logic [BIDX_W-1:0]  bit_idx_q, bit_idx_d;

  always_comb begin
    sreg_d    = sreg_q;
    pre_buf_d = pre_buf_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      sreg_d    = din;
      bit_idx_d = BIT_TOP;
    end else if (shift) begin
      // Crossing an LED boundary pulls the prefetched word in without a bubble.
      if (bit_idx_q == '0) begin
        sreg_d    = pre_buf_q;
        bit_idx_d = BIT_TOP;
      end else begin
        sreg_d    = {sreg_q[COLOR_W-2:0], 1'b0};
        bit_idx_d = bit_idx_q - BIDX_W'(1);
      end
    end
    if (capture) pre_buf_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      pre_buf_q <= '0;
      bit_idx_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      pre_buf_q <= pre_buf_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign bit_out  = sreg_q[COLOR_W-1];
  assign last_bit = (bit_idx_q == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame-level controller feeding the bit transmitter: fetches NUM_LEDS colour words,
// serves them bit by bit, then times the latch period and reports frame completion.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int ADDR_W       = $clog2(NUM_LEDS),
  parameter int LATCH_CYCLES = 5500,
  parameter int AUTO_REFRESH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic busy,
  output logic frame_done,
  led_frame_sequencer_if.master bus
);
  localparam logic              AUTO_ON    = (AUTO_REFRESH != 0);
  localparam logic [ADDR_W-1:0] LAST_LED   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] PF_LIMIT   = ADDR_W'(NUM_LEDS - 2);
  localparam logic [15:0]       LATCH_LAST = 16'(LATCH_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] led_idx_q, led_idx_d;
  logic [15:0]       latch_cnt_q, latch_cnt_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic              pix_rd_q, pix_rd_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              abs_q, abs_d;
  logic              capture_q, capture_d;

  logic sh_load, sh_shift, sh_last;
  logic latch_go, latch_end;

  // Count only once the transmitter has acknowledged the latch window.
  assign latch_go  = bus.new_frame_rqst || (latch_cnt_q != 16'd0);
  assign latch_end = latch_go && (latch_cnt_q == LATCH_LAST);

  // Read data lands one cycle after the strobe; address 0 goes straight to LOAD.
  assign capture_d = pix_rd_q && (pix_addr_q != '0);

  always_comb begin
    state_d      = state_q;
    led_idx_d    = led_idx_q;
    latch_cnt_d  = latch_cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    pix_rd_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    abs_d        = abs_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    if (frame_start && state_q != ST_IDLE) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        abs_d = 1'b1;
        if (frame_start || AUTO_ON) begin
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pix_rd_d   = 1'b1;
        pix_addr_d = ADDR_W'(1);
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        sh_load   = 1'b1;
        led_idx_d = '0;
        abs_d     = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.new_bit_rqst) begin
          if (!sh_last) begin
            sh_shift = 1'b1;
          end else if (led_idx_q != LAST_LED) begin
            sh_shift  = 1'b1;
            led_idx_d = led_idx_q + ADDR_W'(1);
            if (led_idx_q < PF_LIMIT) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = led_idx_q + ADDR_W'(2);
            end
          end else begin
            abs_d       = 1'b1;
            latch_cnt_d = 16'd0;
            state_d     = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (latch_end) begin
          frame_done_d = 1'b1;
          latch_cnt_d  = 16'd0;
          pending_d    = 1'b0;
          if (pending_q || frame_start || AUTO_ON) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = '0;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (latch_go) begin
          latch_cnt_d = latch_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      led_idx_q    <= '0;
      latch_cnt_q  <= 16'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pix_rd_q     <= 1'b0;
      pix_addr_q   <= '0;
      abs_q        <= 1'b1;
      capture_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_idx_q    <= led_idx_d;
      latch_cnt_q  <= latch_cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      pix_rd_q     <= pix_rd_d;
      pix_addr_q   <= pix_addr_d;
      abs_q        <= abs_d;
      capture_q    <= capture_d;
    end
  end

  led_frame_sequencer_pixel_shifter #(.COLOR_W(COLOR_W)) u_pixel_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .capture  (capture_q),
    .shift    (sh_shift),
    .din      (bus.pix_data),
    .bit_out  (bus.bit_to_transmit),
    .last_bit (sh_last)
  );

  assign busy                 = (state_q != ST_IDLE);
  assign frame_done           = frame_done_q;
  assign bus.pix_rd           = pix_rd_q;
  assign bus.pix_addr         = pix_addr_q;
  assign bus.all_bits_shifted = abs_q;

endmodule
